// File: rtl/tdes_pkg.sv
// -----------------------------------------------------------------------------
// tdes_pkg
// Shared types and constants for the Triple-DES (EDE) pass controller.
//   tdes_state_t : controller state encoding (ERR only reachable when the
//                  TDES_TIMEOUT_EN watchdog is built in)
//   KEY1..KEY3   : key index values driven on key_sel
//   DES_ENC/DEC  : single-DES core mode values driven on des_mode
// -----------------------------------------------------------------------------
package tdes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } tdes_state_t;

  localparam logic [1:0] KEY1 = 2'd0;
  localparam logic [1:0] KEY2 = 2'd1;
  localparam logic [1:0] KEY3 = 2'd2;

  localparam logic DES_ENC = 1'b0;
  localparam logic DES_DEC = 1'b1;

endpackage : tdes_pkg

// File: rtl/tdes_pass_controller_pass_schedule.sv
// -----------------------------------------------------------------------------
// pass_schedule
// Combinational EDE pass lookup: (block operation, pass index) -> DES core
// mode and key index.
//   encrypt block : E/K1, D/K2, E/K3
//   decrypt block : D/K3, E/K2, D/K1
// Ports:
//   i_mode      in  1  block operation (0=3DES encrypt, 1=3DES decrypt)
//   i_pass_cnt  in  2  pass index 0..2
//   o_des_mode  out 1  single-DES mode for this pass
//   o_key_sel   out 2  key index for this pass
// -----------------------------------------------------------------------------
module pass_schedule
  import tdes_pkg::*;
(
  input  logic       i_mode,
  input  logic [1:0] i_pass_cnt,
  output logic       o_des_mode,
  output logic [1:0] o_key_sel
);

  // Outer passes run in the block's own direction, the middle pass inverted;
  // decryption walks the key list backwards.
  always_comb begin
    o_des_mode = DES_ENC;
    o_key_sel  = KEY1;
    case (i_pass_cnt)
      2'd0: begin
        o_des_mode = i_mode ? DES_DEC : DES_ENC;
        o_key_sel  = i_mode ? KEY3 : KEY1;
      end
      2'd1: begin
        o_des_mode = i_mode ? DES_ENC : DES_DEC;
        o_key_sel  = KEY2;
      end
      2'd2: begin
        o_des_mode = i_mode ? DES_DEC : DES_ENC;
        o_key_sel  = i_mode ? KEY1 : KEY3;
      end
      default: begin
        o_des_mode = DES_ENC;
        o_key_sel  = KEY1;
      end
    endcase
  end

endmodule : pass_schedule

// File: rtl/tdes_pass_controller.sv
// -----------------------------------------------------------------------------
// tdes_pass_controller
// Sequences the three single-DES passes of a Triple-DES (EDE) block operation.
// Pass 1 reads the fresh input block, passes 2-3 feed the DES output back,
// and the final result is offered to the output shifter.
// Optional build macro: TDES_TIMEOUT_EN (per-pass des_done watchdog + ERR).
// Parameters:
//   TIMEOUT_CYCLES  max WAIT cycles per pass before ERR (watchdog build only)
//   TO_W            watchdog counter width, must hold TIMEOUT_CYCLES
// Ports:
//   i_clk          in  1  system clock, rising edge
//   i_n_rst        in  1  asynchronous active-low reset
//   i_block_valid  in  1  input block ready from byte assembler
//   o_block_ready  out 1  idle, accepts a block
//   i_decrypt      in  1  block operation, sampled at accept
//   o_des_start    out 1  one-cycle start pulse to DES core
//   i_des_done     in  1  DES core result valid
//   o_des_mode     out 1  DES core mode (0=encrypt, 1=decrypt)
//   o_key_sel      out 2  key index (0=K1, 1=K2, 2=K3)
//   o_dir_sel      out 1  0=fresh input / result to output, 1=feedback
//   o_out_valid    out 1  final result available
//   i_out_ready    in  1  output shifter accepts result
//   o_busy         out 1  high in every state except IDLE
//   o_err          out 1  watchdog timeout pulse (constant 0 without macro)
// -----------------------------------------------------------------------------
module tdes_pass_controller
  import tdes_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic       i_clk,
  input  logic       i_n_rst,
  input  logic       i_block_valid,
  output logic       o_block_ready,
  input  logic       i_decrypt,
  output logic       o_des_start,
  input  logic       i_des_done,
  output logic       o_des_mode,
  output logic [1:0] o_key_sel,
  output logic       o_dir_sel,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic       o_busy,
  output logic       o_err
);

  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES >= (1 << TO_W))) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1 and fit in TO_W bits");
  end

  tdes_state_t r_state;
  tdes_state_t w_next_state;
  logic [1:0]  r_pass_cnt;
  logic [1:0]  w_pass_cnt_nxt;
  logic        r_mode_q;
  logic        w_mode_nxt;
  logic        w_sched_mode;
  logic [1:0]  w_sched_key;
  logic        w_err;

`ifdef TDES_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] r_wdog;
  logic [TO_W-1:0] w_wdog_nxt;
`endif

  pass_schedule u_pass_schedule (
    .i_mode     (r_mode_q),
    .i_pass_cnt (r_pass_cnt),
    .o_des_mode (w_sched_mode),
    .o_key_sel  (w_sched_key)
  );

  // State, pass counter, latched operation and (optional) watchdog registers.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      r_state    <= IDLE;
      r_pass_cnt <= 2'd0;
      r_mode_q   <= 1'b0;
`ifdef TDES_TIMEOUT_EN
      r_wdog     <= {TO_W{1'b0}};
`endif
    end else begin
      r_state    <= w_next_state;
      r_pass_cnt <= w_pass_cnt_nxt;
      r_mode_q   <= w_mode_nxt;
`ifdef TDES_TIMEOUT_EN
      r_wdog     <= w_wdog_nxt;
`endif
    end
  end

  // Next-state logic; des_done is only looked at in WAIT, out_ready only in DONE.
  always_comb begin
    w_next_state   = r_state;
    w_pass_cnt_nxt = r_pass_cnt;
    w_mode_nxt     = r_mode_q;
`ifdef TDES_TIMEOUT_EN
    w_wdog_nxt     = r_wdog;
`endif
    case (r_state)
      IDLE: begin
        if (i_block_valid) begin
          w_next_state   = ISSUE;
          w_mode_nxt     = i_decrypt;
          w_pass_cnt_nxt = 2'd0;
        end else begin
          w_next_state = IDLE;
        end
      end
      ISSUE: begin
        w_next_state = WAIT;
`ifdef TDES_TIMEOUT_EN
        w_wdog_nxt   = {TO_W{1'b0}};
`endif
      end
      WAIT: begin
        // A completion in the same cycle as the timeout still counts.
        if (i_des_done) begin
          if (r_pass_cnt == 2'd2) begin
            w_next_state = DONE;
          end else begin
            w_next_state   = ISSUE;
            w_pass_cnt_nxt = r_pass_cnt + 2'd1;
          end
        end
`ifdef TDES_TIMEOUT_EN
        else if (r_wdog == TO_LIMIT) begin
          w_next_state = ERR;
          w_wdog_nxt   = r_wdog + TO_ONE;
        end
`endif
        else begin
          w_next_state = WAIT;
`ifdef TDES_TIMEOUT_EN
          w_wdog_nxt   = r_wdog + TO_ONE;
`endif
        end
      end
      DONE: begin
        if (i_out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      ERR: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Moore output decode from the registered state and pass count.
  always_comb begin
    o_block_ready = 1'b0;
    o_des_start   = 1'b0;
    o_des_mode    = DES_ENC;
    o_key_sel     = KEY1;
    o_dir_sel     = 1'b0;
    o_out_valid   = 1'b0;
    o_busy        = 1'b0;
    w_err         = 1'b0;
    case (r_state)
      IDLE: begin
        o_block_ready = 1'b1;
      end
      ISSUE: begin
        o_des_start = 1'b1;
        o_des_mode  = w_sched_mode;
        o_key_sel   = w_sched_key;
        o_dir_sel   = (r_pass_cnt != 2'd0);
        o_busy      = 1'b1;
      end
      WAIT: begin
        o_des_mode = w_sched_mode;
        o_key_sel  = w_sched_key;
        o_dir_sel  = (r_pass_cnt != 2'd0);
        o_busy     = 1'b1;
      end
      DONE: begin
        o_out_valid = 1'b1;
        o_busy      = 1'b1;
      end
      ERR: begin
        w_err  = 1'b1;
        o_busy = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

`ifdef TDES_TIMEOUT_EN
  assign o_err = w_err;
`else
  // ERR is unreachable without the watchdog, so the decoded flag is unused.
  logic w_err_unused;
  assign w_err_unused = w_err;
  assign o_err        = 1'b0;
`endif

endmodule : tdes_pass_controller

// File: tb/tb_tdes_pass_controller.sv
// -----------------------------------------------------------------------------
// tb_tdes_pass_controller
// Scoreboard bench: the driver pushes the expected pass schedule and latency
// of every accepted block; a negedge monitor pops and compares as the DUT
// issues des_start pulses and raises out_valid. A behavioural DES core model
// answers each start after a per-block latency N and injects spurious
// des_done pulses outside WAIT.
// -----------------------------------------------------------------------------
module tb_tdes_pass_controller;

  typedef struct {
    logic       mode;
    logic [1:0] key;
    logic       dir;
  } pass_t;

  typedef struct {
    int acc;
    int lat;
  } lat_t;

  logic       clk;
  logic       n_rst;
  logic       block_valid;
  logic       block_ready;
  logic       decrypt;
  logic       des_start;
  logic       des_done;
  logic       des_mode;
  logic [1:0] key_sel;
  logic       dir_sel;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       err;

  int    n_vec   = 0;
  int    n_err   = 0;
  int    cyc     = 0;
  int    n_starts = 0;
  int    cur_n   = 1;
  int    resp_rem = 0;
  bit    resp_mute = 1'b0;
  bit    spur_en = 1'b0;
  pass_t exp_q[$];
  lat_t  lat_q[$];

  // Reference schedule tables: index = pass number.
  bit       enc_mode_t[3] = '{1'b0, 1'b1, 1'b0};
  bit [1:0] enc_key_t[3]  = '{2'd0, 2'd1, 2'd2};
  bit       dec_mode_t[3] = '{1'b1, 1'b0, 1'b1};
  bit [1:0] dec_key_t[3]  = '{2'd2, 2'd1, 2'd0};

`ifdef TDES_TIMEOUT_EN
  tdes_pass_controller #(.TIMEOUT_CYCLES(8), .TO_W(8)) dut (
`else
  tdes_pass_controller dut (
`endif
    .i_clk         (clk),
    .i_n_rst       (n_rst),
    .i_block_valid (block_valid),
    .o_block_ready (block_ready),
    .i_decrypt     (decrypt),
    .o_des_start   (des_start),
    .i_des_done    (des_done),
    .o_des_mode    (des_mode),
    .o_key_sel     (key_sel),
    .o_dir_sel     (dir_sel),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_busy        (busy),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic push_block(input bit dec, input int n);
    pass_t p;
    lat_t  l;
    for (int i = 0; i < 3; i++) begin
      p.mode = dec ? dec_mode_t[i] : enc_mode_t[i];
      p.key  = dec ? dec_key_t[i]  : enc_key_t[i];
      p.dir  = (i != 0);
      exp_q.push_back(p);
    end
    l.acc = cyc;
    l.lat = 3 * (n + 1) + 1;
    lat_q.push_back(l);
  endtask

  // Raise block_valid and wait (bounded) for the accepting cycle; returns 1 on accept.
  task automatic offer_block(input bit dec, input int n, output bit ok);
    ok = 1'b0;
    cur_n = n;
    decrypt = dec;
    block_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (block_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      push_block(dec, n);
    end else begin
      fail_now("accept_timeout");
    end
    @(negedge clk);
    block_valid = 1'b0;
    decrypt = $urandom_range(0, 1);
  endtask

  task automatic send_block(input bit dec, input int n, input int hold, input bit poke);
    bit ok;
    bit seen;
    offer_block(dec, n, ok);
    if (ok) begin
      seen = 1'b0;
      for (int t = 0; t < 300; t++) begin
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) begin
        fail_now("out_valid_timeout");
      end else begin
        block_valid = poke;
        decrypt = $urandom_range(0, 1);
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          check("hold_out_valid", {7'd0, out_valid}, 8'd1);
          check("hold_dir_sel", {7'd0, dir_sel}, 8'd0);
          check("hold_block_ready", {7'd0, block_ready}, 8'd0);
        end
        block_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_release", {7'd0, block_ready}, 8'd1);
        check("busy_after_release", {7'd0, busy}, 8'd0);
      end
    end
  endtask

  // Behavioural single-DES core plus spurious des_done injection outside WAIT.
  always @(negedge clk) begin
    bit done_m;
    bit spur;
    done_m = 1'b0;
    if (resp_rem > 0) begin
      if (resp_rem == 1 && !resp_mute) done_m = 1'b1;
      resp_rem--;
    end
    if (des_start) resp_rem = cur_n;
    spur = spur_en && ($urandom_range(0, 3) == 0) && (des_start || block_ready || out_valid);
    des_done = done_m || spur;
  end

  // Scoreboard monitor.
  bit prev_start = 1'b0;
  bit prev_ov    = 1'b0;
  always @(negedge clk) begin
    pass_t e;
    lat_t  l;
    if (des_start) begin
      n_starts++;
      check("start_width", {7'd0, prev_start}, 8'd0);
      if (exp_q.size() == 0) begin
        fail_now("unexpected_des_start");
      end else begin
        e = exp_q.pop_front();
        check("pass_mode_key_dir", {4'd0, des_mode, key_sel, dir_sel}, {4'd0, e.mode, e.key, e.dir});
      end
    end
    if (out_valid && !prev_ov) begin
      if (lat_q.size() == 0) begin
        fail_now("unexpected_out_valid");
      end else begin
        l = lat_q.pop_front();
        check("latency", 8'(cyc - l.acc), 8'(l.lat));
        check("passes_issued", 8'(exp_q.size()), 8'd0);
        check("done_outputs", {3'd0, block_ready, dir_sel, des_mode, key_sel} | {7'd0, err}, 8'd0);
      end
    end
    prev_start = des_start;
    prev_ov    = out_valid;
  end

  initial begin
    bit ok;
    int base;
    n_rst = 1'b0;
    block_valid = 1'b0;
    decrypt = 1'b0;
    out_ready = 1'b0;
    des_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_block_ready", {7'd0, block_ready}, 8'd1);
    check("rst_des_start", {7'd0, des_start}, 8'd0);
    check("rst_mode_key_dir", {4'd0, des_mode, key_sel, dir_sel}, 8'd0);
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_busy_err", {6'd0, busy, err}, 8'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Directed: encrypt N=4, decrypt N=1, backpressure with a poked block_valid.
    send_block(1'b0, 4, 0, 1'b0);
    send_block(1'b1, 1, 0, 1'b0);
    send_block(1'b0, 2, 10, 1'b1);

    // Reset during pass-2 WAIT.
    base = n_starts;
    offer_block(1'b0, 6, ok);
    for (int t = 0; t < 100; t++) begin
      if (n_starts >= base + 2) break;
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", {7'd0, busy}, 8'd1);
    #1 n_rst = 1'b0;
    #1;
    check("midrst_block_ready", {7'd0, block_ready}, 8'd1);
    check("midrst_start_valid", {6'd0, des_start, out_valid}, 8'd0);
    check("midrst_mode_key_dir", {4'd0, des_mode, key_sel, dir_sel}, 8'd0);
    check("midrst_busy_err", {6'd0, busy, err}, 8'd0);
    exp_q.delete();
    lat_q.delete();
    resp_rem = 0;
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {7'd0, block_ready}, 8'd1);

    // Randomized blocks with spurious des_done outside WAIT.
    spur_en = 1'b1;
    for (int b = 0; b < 25; b++) begin
      send_block(1'($urandom_range(0, 1)), $urandom_range(1, 6), $urandom_range(0, 4),
                 1'($urandom_range(0, 1)));
    end
    spur_en = 1'b0;

`ifdef TDES_TIMEOUT_EN
    begin
      int  k;
      bit  seen;
      resp_mute = 1'b1;
      cur_n = 1;
      decrypt = 1'b0;
      block_valid = 1'b1;
      while (!block_ready) @(negedge clk);
      push_block(1'b0, 1);
      @(negedge clk);
      block_valid = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 20; t++) begin
        if (des_start) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      k = 0;
      for (int t = 0; t < 40; t++) begin
        @(negedge clk);
        k++;
        if (err) break;
      end
      check("timeout_start_seen", {7'd0, seen}, 8'd1);
      check("timeout_err_cycle", 8'(k), 8'd9);
      @(negedge clk);
      check("timeout_err_pulse", {7'd0, err}, 8'd0);
      check("timeout_idle", {7'd0, block_ready}, 8'd1);
      exp_q.delete();
      lat_q.delete();
      resp_rem = 0;
      resp_mute = 1'b0;
    end
`endif

    repeat (4) @(negedge clk);
    check("exp_q_drained", 8'(exp_q.size()), 8'd0);
    check("lat_q_drained", 8'(lat_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule : tb_tdes_pass_controller

// File: doc/tdes_pass_controller.md
Name: tdes_pass_controller

Overview:
- Sequences the three DES passes of Triple-DES (EDE) over one 64-bit block.
- Drives the direction-select mux: pass 1 takes the fresh input block; passes 2–3 feed DES output back into DES; the final result goes to the output path.
- Sits between the input byte assembler, the single-DES core and the output shifter in the I2C Triple-DES top level.
- Issues per-pass key select and encrypt/decrypt mode to the DES core.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for des_done per pass. Used only with TDES_TIMEOUT_EN.
- TO_W, 8: width of the watchdog counter. Must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- block_valid  in  1  64-bit input block ready from byte assembler
- block_ready  out  1  controller idle, accepts block
- decrypt  in  1  operation for the block, sampled at accept; 0=3DES encrypt, 1=3DES decrypt
- des_start  out  1  one-cycle start pulse to DES core
- des_done  in  1  DES core result valid (pulse)
- des_mode  out  1  DES core mode; 0=encrypt, 1=decrypt
- key_sel  out  2  key index for DES core; 0=K1, 1=K2, 2=K3
- dir_sel  out  1  direction-select mux control; 0=fresh input / result to output, 1=feedback
- out_valid  out  1  final 64-bit result available on output_data path
- out_ready  in  1  output shifter accepts result
- busy  out  1  high in any state except IDLE
- err  out  1  timeout error pulse; tied 0 without TDES_TIMEOUT_EN

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous, active-low.
- Reset: state=IDLE, pass_cnt=0, mode_q=0, watchdog=0. Outputs after reset:
  - block_ready=1
  - des_start=0, des_mode=0, key_sel=0, dir_sel=0
  - out_valid=0, busy=0, err=0
- Output style: all outputs are Moore, decoded from registered state, pass_cnt and mode_q.
- States: IDLE, ISSUE, WAIT, DONE, plus ERR with TDES_TIMEOUT_EN.
- IDLE:
  - block_ready=1.
  - On block_valid=1: latch mode_q<=decrypt, pass_cnt<=0, go to ISSUE.
- ISSUE:
  - des_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - des_start=0.
  - On des_done=1: if pass_cnt==2 go to DONE; otherwise pass_cnt++ and go to ISSUE.
  - des_done is ignored in every state other than WAIT.
- DONE:
  - out_valid=1, dir_sel=0.
  - Hold until out_ready=1, then go to IDLE.
  - out_ready while not in DONE is ignored.
- dir_sel:
  - 1 in ISSUE/WAIT when pass_cnt!=0.
  - 0 in ISSUE/WAIT when pass_cnt==0.
  - 0 in IDLE and DONE.
- Pass schedule (pass_cnt 0,1,2), as des_mode/key_sel:
  - encrypt (mode_q=0): E/K1, D/K2, E/K3
  - decrypt (mode_q=1): D/K3, E/K2, D/K1
  - Valid in ISSUE and WAIT. In IDLE and DONE: des_mode=0, key_sel=0.
- Latency: if DES returns des_done N cycles after des_start (N≥1), accept-to-out_valid = 3·(N+1)+1 cycles.
- des_done in the same cycle as entering WAIT counts as completion.
- A new block is not accepted until DONE completes; block_ready=0 throughout.
- Reset mid-operation: immediate return to IDLE. des_start and out_valid drop asynchronously; the in-flight block is discarded.

Optional Feature:
- Macro: TDES_TIMEOUT_EN.
- With macro:
  - Watchdog clears on entering WAIT and increments each WAIT cycle without des_done.
  - When it reaches TIMEOUT_CYCLES: go to ERR. ERR asserts err=1 for one cycle, then goes to IDLE; the block is dropped.
  - des_done and timeout in the same cycle: des_done wins.
- Without macro: no counter and no ERR state; WAIT waits forever; err is constant 0.

Decomposition:
- Package tdes_pkg holds:
  - state enum tdes_state_t {IDLE, ISSUE, WAIT, DONE, ERR}
  - key index constants KEY1=2'd0, KEY2=2'd1, KEY3=2'd2
  - DES_ENC=1'b0, DES_DEC=1'b1
- Optional sub-module: pass_schedule, a combinational (mode_q, pass_cnt) → (des_mode, key_sel) lookup.
- The watchdog stays inline under the macro.

Test Plan:
- Encrypt, N=4: block_valid with decrypt=0.
  - Pass order (des_mode,key_sel) = (0,0),(1,1),(0,2); dir_sel = 0,1,1.
  - out_valid in the 16th cycle after accept.
- Decrypt, N=1: pass order (1,2),(0,1),(1,0); exactly three des_start pulses, each one cycle wide.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_valid stays 1, dir_sel stays 0, block_ready stays 0, and a new block_valid is not accepted.
  - Release out_ready → IDLE next cycle.
- Spurious des_done asserted in IDLE, ISSUE and DONE: no state change, pass_cnt unchanged.
- Reset mid-operation: assert n_rst=0 during pass 2 WAIT. All outputs reach reset values before the next clk edge; block_ready=1 after release.
- With TDES_TIMEOUT_EN and TIMEOUT_CYCLES=8: withhold des_done in pass 1. err pulses for one cycle after 8 WAIT cycles, then back to IDLE.
